rat_intr_ctrl: RTL and testbench
================================

Name: rat_intr_ctrl

Overview:
Multi-source interrupt controller for the RAT CPU; the initiator side of the control unit's INT_CU input.
- Synchronises asynchronous peripheral IRQ lines and edge-detects them.
- Latches pending bits and applies a software mask.
- Drives a registered INT_CU level to CONTROL_UNIT.
- Software services it through the RAT I/O bus (PORT_ID/OUT_PORT/IO_STRB writes, IN_PORT reads).

Parameters:
N_SRC, 4, number of interrupt sources (legal 1..8); index 0 is highest priority.
PEND_ID, 8'h30, I/O port: read raw pending; write-1-to-clear pending and overrun.
MASK_ID, 8'h31, I/O port: read/write enable mask (1 = enabled).
OVR_ID, 8'h32, I/O port: read overrun flags (read-only).
VEC_ID, 8'h33, I/O port: read {INT_CU, 4'b0, idx[2:0]} (read-only).

Ports:
CLK  in  1  system clock, rising edge.
RESET_N  in  1  asynchronous, active-low reset.
IRQ  in  N_SRC  asynchronous peripheral requests; rising edge = request.
PORT_ID  in  8  I/O address from the CPU.
OUT_PORT  in  8  I/O write data from the CPU.
IO_STRB  in  1  one-cycle write strobe from CONTROL_UNIT.
INT_CU  out  1  interrupt request level to CONTROL_UNIT.
IN_DATA  out  8  read data for the CPU IN_PORT mux (combinational on PORT_ID).
IN_HIT  out  1  high when PORT_ID matches any of the four port IDs.

Behaviour:
Reset (RESET_N low, async):
- All synchroniser flops, pending, mask, overrun and INT_CU clear to 0.
- All sources are masked at reset.
- Reset mid-operation discards all pending and overrun state immediately.

Per source: 3-flop chain s1->s2->s3, edge = s2 & ~s3.
- Latency: IRQ high setup before edge E1 gives s1=1 at E1, s2=1 at E2, pending set at E3.
- INT_CU is registered and rises at E4 if the source is unmasked.
- IRQ pulses shorter than 1 CLK period may be lost; no requirement on them.
- A level held high produces exactly one edge.

Pending and overrun:
- edge sets pending[i]; edge while pending[i] already 1 sets ovr[i] (sticky).
- W1C write (IO_STRB & PORT_ID==PEND_ID) clears pending[i] and ovr[i] for each OUT_PORT[i]=1.
- Edge and W1C on the same bit in the same cycle: set wins, pending stays 1; ovr takes its normal update (cleared, since the old value was cleared).

Mask:
- Write (IO_STRB & PORT_ID==MASK_ID) loads OUT_PORT[N_SRC-1:0].
- Bits at or above N_SRC are ignored on write and read as 0.

INT_CU:
- Next value = |(pending & mask); registered, so a mask or ack write affects INT_CU one cycle later.
- Level-held, not pulsed; it stays high until software clears or masks every active source.

VEC read:
- idx = lowest i with pending[i] & mask[i]; 0 when none.
- bit7 = current INT_CU.

Other bus rules:
- Writes to OVR_ID or VEC_ID, or to unmatched IDs, have no effect.
- IN_DATA = 8'h00 when there is no hit.
- IO_STRB with a matching ID is honoured every cycle; back-to-back writes are legal.

Decomposition:
- Package rat_intr_pkg holds the four default port-ID localparams, MAX_SRC=8, and a function for the priority encoder (lowest set index).
- Sub-module irq_sync_edge: one instance per source. It holds the 3-flop synchroniser with async active-low reset and outputs a one-cycle edge pulse.

Test Plan:
1. Reset value: RESET_N=0 for 3 cycles, then 1 -> INT_CU=0; reads PEND/MASK/OVR return 8'h00; VEC returns 8'h00.
2. Masked vs unmasked request:
   - IRQ[2] rises, mask=0 -> PEND reads 8'h04 and INT_CU stays 0.
   - Write MASK=8'h04 -> INT_CU=1 one cycle after the strobe.
   - VEC reads 8'h82.
3. Latency and priority:
   - mask=8'h0F; IRQ[3] rises before E1 -> INT_CU=1 at E4.
   - Then IRQ[1] rises -> VEC reads 8'h81.
   - W1C 8'h02 -> VEC reads 8'h83.
   - W1C 8'h08 -> INT_CU=0 the following cycle.
4. Overrun: with pending[0]=1, a second IRQ[0] rising edge -> OVR reads 8'h01; W1C 8'h01 -> PEND=8'h00 and OVR=8'h00.
5. Simultaneous set and clear: the edge on bit 1 coincides with W1C 8'h02 -> PEND reads 8'h02 and INT_CU stays/goes high when mask[1]=1.
6. Async reset mid-operation: pending=8'h05, INT_CU=1; RESET_N pulsed low between clock edges -> INT_CU=0 immediately with no clock; all registers read 0 afterwards.

Source files
------------

// File: rtl/rat_intr_pkg.sv
// Shared constants and helpers for the RAT interrupt controller.
// Default I/O port IDs, source limit and a priority encoder.
package rat_intr_pkg;

  localparam int MAX_SRC = 8;

  localparam logic [7:0] PEND_ID_DEF = 8'h30;
  localparam logic [7:0] MASK_ID_DEF = 8'h31;
  localparam logic [7:0] OVR_ID_DEF  = 8'h32;
  localparam logic [7:0] VEC_ID_DEF  = 8'h33;

  function automatic logic [2:0] lowest_set(
    input logic [MAX_SRC-1:0] v
  );
    lowest_set = 3'd0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = 3'(i);
    end
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// 3-flop synchroniser plus rising-edge detector for one IRQ line.
// Ports: CLK, RESET_N (async low), irq (async in), rise (1-cycle pulse).
module irq_sync_edge (
  input  logic CLK,
  input  logic RESET_N,
  input  logic irq,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= irq;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/rat_intr_ctrl.sv
// Multi-source interrupt controller driving INT_CU of the RAT CPU.
// Ports: CLK, RESET_N, IRQ, PORT_ID/OUT_PORT/IO_STRB, INT_CU, IN_DATA, IN_HIT.
module rat_intr_ctrl
  import rat_intr_pkg::*;
#(
  parameter int         N_SRC   = 4,
  parameter logic [7:0] PEND_ID = PEND_ID_DEF,
  parameter logic [7:0] MASK_ID = MASK_ID_DEF,
  parameter logic [7:0] OVR_ID  = OVR_ID_DEF,
  parameter logic [7:0] VEC_ID  = VEC_ID_DEF
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [N_SRC-1:0] IRQ,
  input  logic [7:0]       PORT_ID,
  input  logic [7:0]       OUT_PORT,
  input  logic             IO_STRB,
  output logic             INT_CU,
  output logic [7:0]       IN_DATA,
  output logic             IN_HIT
);

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] ovr;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] pend_nxt;
  logic [N_SRC-1:0] ovr_nxt;
  logic             int_q;

  logic hit_pend;
  logic hit_mask;
  logic hit_ovr;
  logic hit_vec;
  logic pend_wr;
  logic mask_wr;

  logic [MAX_SRC-1:0] pend8;
  logic [MAX_SRC-1:0] mask8;
  logic [MAX_SRC-1:0] ovr8;
  logic [2:0]         idx;

  logic unused_ok;
  assign unused_ok = &{1'b0, OUT_PORT};

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    irq_sync_edge u_sync (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .irq     (IRQ[g]),
      .rise    (rise[g])
    );
  end

  assign hit_pend = (PORT_ID == PEND_ID);
  assign hit_mask = (PORT_ID == MASK_ID);
  assign hit_ovr  = (PORT_ID == OVR_ID);
  assign hit_vec  = (PORT_ID == VEC_ID);
  assign IN_HIT   = hit_pend | hit_mask
                  | hit_ovr  | hit_vec;

  assign pend_wr = IO_STRB & hit_pend;
  assign mask_wr = IO_STRB & hit_mask;

  assign clr = pend_wr ? OUT_PORT[N_SRC-1:0]
                       : '0;

  // A new edge beats a same-cycle clear.
  // Overrun only counts against a pending
  // bit that survives this cycle's clear.
  assign pend_nxt = (pend & ~clr) | rise;
  assign ovr_nxt  = (ovr | (rise & pend))
                  & ~clr;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pend  <= '0;
      ovr   <= '0;
      mask  <= '0;
      int_q <= 1'b0;
    end else begin
      pend  <= pend_nxt;
      ovr   <= ovr_nxt;
      int_q <= |(pend & mask);
      if (mask_wr) begin
        mask <= OUT_PORT[N_SRC-1:0];
      end
    end
  end

  assign INT_CU = int_q;

  assign pend8 = MAX_SRC'(pend);
  assign mask8 = MAX_SRC'(mask);
  assign ovr8  = MAX_SRC'(ovr);
  assign idx   = lowest_set(pend8 & mask8);

  always_comb begin
    IN_DATA = 8'h00;
    unique case (1'b1)
      hit_pend: IN_DATA = pend8;
      hit_mask: IN_DATA = mask8;
      hit_ovr:  IN_DATA = ovr8;
      hit_vec:  IN_DATA = {int_q, 4'b0, idx};
      default:  IN_DATA = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_rat_intr_ctrl.sv
// Scoreboard bench for rat_intr_ctrl with a behavioural model.
// Directed scenarios followed by randomized bus and IRQ traffic.
module tb_rat_intr_ctrl;

  localparam logic [7:0] P_PEND = 8'h30;
  localparam logic [7:0] P_MASK = 8'h31;
  localparam logic [7:0] P_OVR  = 8'h32;
  localparam logic [7:0] P_VEC  = 8'h33;

  logic       CLK;
  logic       RESET_N;
  logic [3:0] IRQ;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       IO_STRB;
  logic       INT_CU;
  logic [7:0] IN_DATA;
  logic       IN_HIT;

  logic       rd_en;
  logic [8:0] sb[$];
  int         checks = 0;
  int         errors = 0;
  int         rst_req = 0;
  int         rst_ack = 0;
  logic       rst_seen;

  rat_intr_ctrl #(.N_SRC(4)) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .IRQ      (IRQ),
    .PORT_ID  (PORT_ID),
    .OUT_PORT (OUT_PORT),
    .IO_STRB  (IO_STRB),
    .INT_CU   (INT_CU),
    .IN_DATA  (IN_DATA),
    .IN_HIT   (IN_HIT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference model. A line sampled high at
  // edge k (low at k-1) becomes pending at
  // edge k+2; INT_CU lags pend&mask by one.
  logic [3:0] m_pend;
  logic [3:0] m_mask;
  logic [3:0] m_ovr;
  logic       m_int;
  logic [3:0] m_req;
  logic [3:0] m_clr;
  logic [3:0] samp [0:2];

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_pend = 4'h0;
      m_mask = 4'h0;
      m_ovr  = 4'h0;
      m_int  = 1'b0;
      for (int i = 0; i < 3; i++) samp[i] = 4'h0;
    end else begin
      m_req = samp[1] & ~samp[2];
      m_clr = 4'h0;
      if (IO_STRB && PORT_ID == P_PEND)
        m_clr = OUT_PORT[3:0];
      m_int  = |(m_pend & m_mask);
      m_ovr  = (m_ovr | (m_req & m_pend)) & ~m_clr;
      m_pend = (m_pend & ~m_clr) | m_req;
      if (IO_STRB && PORT_ID == P_MASK)
        m_mask = OUT_PORT[3:0];
      samp[2] = samp[1];
      samp[1] = samp[0];
      samp[0] = IRQ;
    end
  end

  function automatic logic [8:0] exp_read(
    input logic [7:0] id
  );
    logic [3:0] act;
    logic [2:0] n;
    act = m_pend & m_mask;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (act[i]) begin
        n = 3'(i);
        break;
      end
    end
    case (id)
      P_PEND:  return {5'b10000, m_pend};
      P_MASK:  return {5'b10000, m_mask};
      P_OVR:   return {5'b10000, m_ovr};
      P_VEC:   return {1'b1, m_int, 4'b0, n};
      default: return 9'h000;
    endcase
  endfunction

  always @(negedge CLK) begin
    logic [8:0] e;
    #2;
    checks++;
    if (INT_CU !== m_int) begin
      errors++;
      $display("FAIL int_cu act=%b exp=%b t=%0t",
               INT_CU, m_int, $time);
    end
    if (rst_req != rst_ack) begin
      rst_ack = rst_req;
      checks++;
      if (rst_seen !== 1'b0) begin
        errors++;
        $display("FAIL async_rst act=%b exp=0",
                 rst_seen);
      end
    end
    if (rd_en) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rd_empty id=%h", PORT_ID);
      end else begin
        e = sb.pop_front();
        if ({IN_HIT, IN_DATA} !== e) begin
          errors++;
          $display("FAIL rd id=%h act=%b/%h exp=%b/%h t=%0t",
                   PORT_ID, IN_HIT, IN_DATA,
                   e[8], e[7:0], $time);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      IO_STRB = 1'b0;
      rd_en   = 1'b0;
    end
  endtask

  task automatic wr(input logic [7:0] id,
                    input logic [7:0] d);
    @(negedge CLK);
    rd_en    = 1'b0;
    IO_STRB  = 1'b1;
    PORT_ID  = id;
    OUT_PORT = d;
  endtask

  task automatic set_irq(input logic [3:0] v);
    @(negedge CLK);
    IO_STRB = 1'b0;
    rd_en   = 1'b0;
    IRQ     = v;
  endtask

  task automatic rd_const(input logic [7:0] id,
                          input logic [7:0] d);
    @(negedge CLK);
    IO_STRB = 1'b0;
    PORT_ID = id;
    rd_en   = 1'b1;
    sb.push_back({1'b1, d});
  endtask

  task automatic rd_model(input logic [7:0] id);
    @(negedge CLK);
    IO_STRB = 1'b0;
    PORT_ID = id;
    rd_en   = 1'b1;
    sb.push_back(exp_read(id));
  endtask

  initial begin
    logic [7:0] ids [0:3];
    logic [7:0] id;
    ids[0] = P_PEND;
    ids[1] = P_MASK;
    ids[2] = P_OVR;
    ids[3] = P_VEC;
    RESET_N  = 1'b0;
    IRQ      = 4'h0;
    PORT_ID  = 8'h00;
    OUT_PORT = 8'h00;
    IO_STRB  = 1'b0;
    rd_en    = 1'b0;
    rst_seen = 1'b0;
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;

    rd_const(P_PEND, 8'h00);
    rd_const(P_MASK, 8'h00);
    rd_const(P_OVR,  8'h00);
    rd_const(P_VEC,  8'h00);

    set_irq(4'b0100);
    idle(4);
    rd_const(P_PEND, 8'h04);
    wr(P_MASK, 8'h04);
    idle(1);
    rd_const(P_VEC, 8'h82);
    wr(P_PEND, 8'h04);
    wr(P_MASK, 8'h00);
    idle(2);

    wr(P_MASK, 8'h0F);
    set_irq(4'b1100);
    idle(4);
    set_irq(4'b1110);
    idle(4);
    rd_const(P_VEC, 8'h81);
    wr(P_PEND, 8'h02);
    idle(1);
    rd_const(P_VEC, 8'h83);
    wr(P_PEND, 8'h08);
    idle(2);
    rd_const(P_PEND, 8'h00);

    set_irq(4'b1111);
    idle(4);
    set_irq(4'b1110);
    idle(2);
    set_irq(4'b1111);
    idle(4);
    rd_const(P_OVR, 8'h01);
    wr(P_PEND, 8'h01);
    rd_const(P_PEND, 8'h00);
    rd_const(P_OVR,  8'h00);

    set_irq(4'b1101);
    idle(3);
    set_irq(4'b1111);
    idle(1);
    wr(P_PEND, 8'h02);
    idle(1);
    rd_const(P_PEND, 8'h02);
    rd_const(P_OVR,  8'h00);

    wr(P_PEND, 8'h02);
    set_irq(4'b1010);
    idle(3);
    set_irq(4'b1111);
    idle(5);
    rd_const(P_PEND, 8'h05);
    @(negedge CLK);
    rd_en = 1'b0;
    #3;
    RESET_N = 1'b0;
    IRQ     = 4'h0;
    #1;
    rst_seen = INT_CU;
    rst_req++;
    @(negedge CLK);
    RESET_N = 1'b1;
    rd_const(P_PEND, 8'h00);
    rd_const(P_MASK, 8'h00);
    rd_const(P_OVR,  8'h00);
    rd_const(P_VEC,  8'h00);

    for (int k = 0; k < 600; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: idle(1);
        3: set_irq(4'($urandom));
        4: wr(P_PEND, 8'($urandom));
        5: wr(P_MASK, 8'($urandom));
        6: begin
          id = ids[$urandom_range(2, 3)];
          if ($urandom_range(0, 1) == 1)
            id = 8'($urandom);
          wr(id, 8'($urandom));
        end
        default: begin
          id = ids[$urandom_range(0, 3)];
          if ($urandom_range(0, 4) == 0)
            id = 8'($urandom);
          rd_model(id);
        end
      endcase
    end
    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
